// File: rtl/region_plotter.sv
// Sweeps a rectangular screen region through a synchronous pixel ROM and emits
// one (x, y, color_draw, plot) draw command per cycle to the frame-buffer writer.
module region_plotter #(
  parameter int          XW     = 8,
  parameter int          YW     = 8,
  parameter int          CW     = 3,
  parameter int          RD_LAT = 1,
  parameter int unsigned KEY    = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [1:0]    mode,
  input  logic [XW-1:0] x0,
  input  logic [YW-1:0] y0,
  input  logic [XW-1:0] w,
  input  logic [YW-1:0] h,
  input  logic [CW-1:0] fill_color,
  output logic [XW-1:0] mem_x,
  output logic [YW-1:0] mem_y,
  input  logic [CW-1:0] mem_dout,
  output logic [XW-1:0] x,
  output logic [YW-1:0] y,
  output logic [CW-1:0] color_draw,
  output logic          plot,
  output logic          busy,
  output logic          done,
  output logic [1:0]    state
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SWEEP = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] M_COPY   = 2'd0;
  localparam logic [1:0] M_FILL   = 2'd1;
  localparam logic [1:0] M_KEYED  = 2'd2;
  localparam logic [1:0] M_INVERT = 2'd3;

  logic [1:0]    mode_r;
  logic [XW-1:0] x0_r;
  logic [XW-1:0] w_r;
  logic [YW-1:0] h_r;
  logic [CW-1:0] fill_r;
  logic [XW-1:0] cx;
  logic [YW-1:0] cy;
  logic [2:0]    drain_cnt;
  logic          vld_p0;
  logic [RD_LAT:1] vld_dl;
  logic [XW-1:0] x_dl [1:RD_LAT];
  logic [YW-1:0] y_dl [1:RD_LAT];
  logic          last_col;
  logic          last_row;
  logic          pix_show;

  function automatic logic [CW-1:0] pixel_color(input logic [1:0] m,
                                                input logic [CW-1:0] d,
                                                input logic [CW-1:0] f);
    case (m)
      M_FILL:   return f;
      M_INVERT: return ~d;
      M_COPY:   return d;
      default:  return d;
    endcase
  endfunction

  function automatic logic pixel_visible(input logic [1:0] m, input logic [CW-1:0] d);
    return !((m == M_KEYED) && (d == CW'(KEY)));
  endfunction

  assign last_col = (cx == w_r - XW'(1));
  assign last_row = (cy == h_r - YW'(1));
  assign busy     = (state == S_SWEEP) || (state == S_DRAIN);
  assign done     = (state == S_DONE);

  // Stage p0: sequencer presents one ROM address per cycle in raster order
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      mem_x     <= '0;
      mem_y     <= '0;
      vld_p0    <= 1'b0;
      cx        <= '0;
      cy        <= '0;
      drain_cnt <= '0;
      mode_r    <= M_COPY;
      x0_r      <= '0;
      w_r       <= '0;
      h_r       <= '0;
      fill_r    <= '0;
    end else begin
      vld_p0 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            mode_r <= mode;
            x0_r   <= x0;
            w_r    <= w;
            h_r    <= h;
            fill_r <= fill_color;
            cx     <= '0;
            cy     <= '0;
            if (w == '0 || h == '0) begin
              state <= S_DONE;
            end else begin
              state  <= S_SWEEP;
              mem_x  <= x0;
              mem_y  <= y0;
              vld_p0 <= 1'b1;
            end
          end
        end
        S_SWEEP: begin
          if (last_col && last_row) begin
            state     <= S_DRAIN;
            drain_cnt <= '0;
          end else if (last_col) begin
            cx     <= '0;
            cy     <= cy + YW'(1);
            mem_x  <= x0_r;
            mem_y  <= mem_y + YW'(1);
            vld_p0 <= 1'b1;
          end else begin
            cx     <= cx + XW'(1);
            mem_x  <= mem_x + XW'(1);
            vld_p0 <= 1'b1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == 3'(RD_LAT)) state <= S_DONE;
          else drain_cnt <= drain_cnt + 3'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stages 1..RD_LAT: coordinates ride alongside the ROM read in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_dl <= '0;
      for (int k = 1; k <= RD_LAT; k++) begin
        x_dl[k] <= '0;
        y_dl[k] <= '0;
      end
    end else begin
      vld_dl[1] <= vld_p0;
      x_dl[1]   <= mem_x;
      y_dl[1]   <= mem_y;
      for (int k = 2; k <= RD_LAT; k++) begin
        vld_dl[k] <= vld_dl[k-1];
        x_dl[k]   <= x_dl[k-1];
        y_dl[k]   <= y_dl[k-1];
      end
    end
  end

  assign pix_show = vld_dl[RD_LAT] && pixel_visible(mode_r, mem_dout);

  // Output stage: ROM data for the oldest address arrives here
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      plot       <= 1'b0;
      x          <= '0;
      y          <= '0;
      color_draw <= '0;
    end else begin
      plot <= pix_show;
      if (pix_show) begin
        x          <= x_dl[RD_LAT];
        y          <= y_dl[RD_LAT];
        color_draw <= pixel_color(mode_r, mem_dout, fill_r);
      end
    end
  end

endmodule

// File: tb/tb_region_plotter.sv
// Directed bench for region_plotter: a one-cycle and a three-cycle ROM instance
// driven from a shared stimulus sequence, each with its own behavioural ROM.
module tb_region_plotter;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start1 = 1'b0;
  logic       start3 = 1'b0;
  logic [1:0] mode = 2'd0;
  logic [7:0] x0 = 8'd0, y0 = 8'd0, w = 8'd0, h = 8'd0;
  logic [2:0] fill_color = 3'd0;
  int         rom_sel = 0;

  logic [7:0] mx1, my1, x1, y1, mx3, my3, x3, y3;
  logic [2:0] dout1 = 3'd0, dout3 = 3'd0, r3a = 3'd0, r3b = 3'd0, c1, c3;
  logic       plot1, busy1, done1, plot3, busy3, done3;
  logic [1:0] st1, st3;

  int vectors = 0;
  int miscompares = 0;

  int q_x[$], q_y[$], q_c[$], q_t[$];
  int done_n, done_t, busy_n;
  int first_mx, first_my;

  always #5 clk = ~clk;

  region_plotter #(.XW(8), .YW(8), .CW(3), .RD_LAT(1)) u1 (
    .clk(clk), .reset(reset), .start(start1), .mode(mode), .x0(x0), .y0(y0),
    .w(w), .h(h), .fill_color(fill_color), .mem_x(mx1), .mem_y(my1),
    .mem_dout(dout1), .x(x1), .y(y1), .color_draw(c1), .plot(plot1),
    .busy(busy1), .done(done1), .state(st1));

  region_plotter #(.XW(8), .YW(8), .CW(3), .RD_LAT(3)) u3 (
    .clk(clk), .reset(reset), .start(start3), .mode(mode), .x0(x0), .y0(y0),
    .w(w), .h(h), .fill_color(fill_color), .mem_x(mx3), .mem_y(my3),
    .mem_dout(dout3), .x(x3), .y(y3), .color_draw(c3), .plot(plot3),
    .busy(busy3), .done(done3), .state(st3));

  function automatic logic [2:0] rom_f(input logic [7:0] ax, input logic [7:0] ay);
    logic [7:0] s;
    s = ax + ay;
    case (rom_sel)
      0:       return s[2:0];
      1:       return ax[0] ? 3'd0 : 3'd3;
      default: return 3'd2;
    endcase
  endfunction

  always @(posedge clk) begin
    dout1 <= rom_f(mx1, my1);
    r3a   <= rom_f(mx3, my3);
    r3b   <= r3a;
    dout3 <= r3b;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Pulses start on the chosen instance, then logs plots, busy and done per cycle.
  task automatic capture(input bit sel, input int ncyc, input bit hold);
    q_x.delete(); q_y.delete(); q_c.delete(); q_t.delete();
    done_n = 0; done_t = -1; busy_n = 0;
    if (sel) start3 = 1'b1; else start1 = 1'b1;
    for (int c = 0; c < ncyc; c++) begin
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
      if (c == 0) begin
        first_mx = sel ? int'(mx3) : int'(mx1);
        first_my = sel ? int'(my3) : int'(my1);
      end
      if (sel ? plot3 : plot1) begin
        q_x.push_back(sel ? int'(x3) : int'(x1));
        q_y.push_back(sel ? int'(y3) : int'(y1));
        q_c.push_back(sel ? int'(c3) : int'(c1));
        q_t.push_back(c);
      end
      if (sel ? busy3 : busy1) busy_n++;
      if (sel ? done3 : done1) begin
        done_n++;
        done_t = c;
        start1 = 1'b0; start3 = 1'b0;
      end
    end
    start1 = 1'b0; start3 = 1'b0;
  endtask

  task automatic setup(input logic [1:0] m, input logic [7:0] ax, input logic [7:0] ay,
                       input logic [7:0] aw, input logic [7:0] ah, input logic [2:0] f);
    mode = m; x0 = ax; y0 = ay; w = aw; h = ah; fill_color = f;
  endtask

  initial begin
    int ex[$], ec[$];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", st1, 0);
    chk("rst_plot", plot1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_mem_x", mx1, 0);
    chk("rst_x", x1, 0);
    chk("rst_color", c1, 0);
    reset = 1'b0;
    @(posedge clk); #1;

    // COPY, 3x2 at (10,20), ROM = (x+y)&7
    rom_sel = 0;
    setup(2'd0, 8'd10, 8'd20, 8'd3, 8'd2, 3'd0);
    capture(1'b0, 12, 1'b0);
    chk("copy_first_mem_x", first_mx, 10);
    chk("copy_first_mem_y", first_my, 20);
    chk("copy_nplots", q_x.size(), 6);
    ex = '{10, 11, 12, 10, 11, 12};
    ec = '{6, 7, 0, 7, 0, 1};
    for (int i = 0; i < 6 && i < q_x.size(); i++) begin
      chk($sformatf("copy_x%0d", i), q_x[i], ex[i]);
      chk($sformatf("copy_y%0d", i), q_y[i], (i < 3) ? 20 : 21);
      chk($sformatf("copy_c%0d", i), q_c[i], ec[i]);
      chk($sformatf("copy_t%0d", i), q_t[i], 2 + i);
    end
    chk("copy_done_n", done_n, 1);
    chk("copy_done_t", done_t, 8);
    chk("copy_busy_n", busy_n, 8);

    // FILL wrapping across x=255
    setup(2'd1, 8'd254, 8'd7, 8'd4, 8'd1, 3'd5);
    capture(1'b0, 10, 1'b0);
    chk("fill_nplots", q_x.size(), 4);
    ex = '{254, 255, 0, 1};
    for (int i = 0; i < 4 && i < q_x.size(); i++) begin
      chk($sformatf("fill_x%0d", i), q_x[i], ex[i]);
      chk($sformatf("fill_y%0d", i), q_y[i], 7);
      chk($sformatf("fill_c%0d", i), q_c[i], 5);
    end

    // KEYED with key 0 at odd x
    rom_sel = 1;
    setup(2'd2, 8'd0, 8'd3, 8'd4, 8'd1, 3'd0);
    capture(1'b0, 10, 1'b0);
    chk("keyed_nplots", q_x.size(), 2);
    if (q_x.size() >= 2) begin
      chk("keyed_x0", q_x[0], 0);
      chk("keyed_x1", q_x[1], 2);
      chk("keyed_c0", q_c[0], 3);
      chk("keyed_t1", q_t[1], 4);
    end
    chk("keyed_busy_n", busy_n, 6);
    chk("keyed_done_t", done_t, 6);

    // Zero width: straight to done
    setup(2'd0, 8'd1, 8'd1, 8'd0, 8'd5, 3'd0);
    capture(1'b0, 5, 1'b0);
    chk("w0_nplots", q_x.size(), 0);
    chk("w0_done_n", done_n, 1);
    chk("w0_done_t", done_t, 0);
    chk("w0_busy_n", busy_n, 0);

    // start held through busy: one run only
    rom_sel = 0;
    setup(2'd0, 8'd10, 8'd20, 8'd2, 8'd1, 3'd0);
    capture(1'b0, 14, 1'b1);
    chk("hold_nplots", q_x.size(), 2);
    chk("hold_done_n", done_n, 1);
    chk("hold_done_t", done_t, 4);
    chk("hold_state_end", st1, 0);

    // INVERT on the three-cycle ROM instance
    rom_sel = 2;
    setup(2'd3, 8'd5, 8'd6, 8'd2, 8'd1, 3'd0);
    capture(1'b1, 12, 1'b0);
    chk("inv_nplots", q_x.size(), 2);
    if (q_x.size() >= 2) begin
      chk("inv_c0", q_c[0], 5);
      chk("inv_c1", q_c[1], 5);
      chk("inv_t0", q_t[0], 4);
      chk("inv_x1", q_x[1], 6);
    end
    chk("inv_done_t", done_t, 6);
    chk("inv_busy_n", busy_n, 6);

    // Asynchronous reset in the middle of a sweep
    rom_sel = 0;
    setup(2'd0, 8'd0, 8'd0, 8'd8, 8'd2, 3'd0);
    start1 = 1'b1;
    @(posedge clk); #1;
    start1 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_rst_plot", plot1, 1);
    chk("pre_rst_busy", busy1, 1);
    #3 reset = 1'b1;
    #1;
    chk("arst_plot", plot1, 0);
    chk("arst_busy", busy1, 0);
    chk("arst_done", done1, 0);
    chk("arst_state", st1, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_plot", plot1, 0);

    setup(2'd0, 8'd10, 8'd20, 8'd3, 8'd1, 3'd0);
    capture(1'b0, 10, 1'b0);
    chk("fresh_nplots", q_x.size(), 3);
    if (q_c.size() >= 3) begin
      chk("fresh_c0", q_c[0], 6);
      chk("fresh_c2", q_c[2], 0);
    end
    chk("fresh_done_t", done_t, 5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
